// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one TDP RAM port between NUM_REQ requesters.
// Commands are granted combinationally; reads are tracked to tag returning data with the requester id.
module ram_port_arbiter #(
   parameter  int NUM_REQ    = 4,
   parameter  int WIDTH      = 32,
   parameter  int DEPTH      = 1024,
   parameter  int RD_LATENCY = 1,
   localparam int AW         = $clog2(DEPTH),
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   input  logic [NUM_REQ-1:0]       req_we_i,
   input  logic [NUM_REQ*AW-1:0]    req_addr_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   output logic                     mem_we_o,
   output logic [AW-1:0]            mem_addr_o,
   output logic [WIDTH-1:0]         mem_din_o,
   input  logic [WIDTH-1:0]         mem_dout_i,
   output logic                     rsp_valid_o,
   output logic [ID_W-1:0]          rsp_id_o,
   output logic [WIDTH-1:0]         rsp_data_o
);

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            gnt_vld;
   logic [ID_W-1:0] gnt_id;
   logic            rd_push;

   logic [RD_LATENCY-1:0]           vld_pipe_q, vld_pipe_d;
   logic [RD_LATENCY-1:0][ID_W-1:0] id_pipe_q, id_pipe_d;

   // Scan from rr_ptr upward with wraparound; the first valid requester wins.
   always_comb begin
      int idx;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_vld && req_valid_i[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = ID_W'(idx);
         end
      end
      // Nothing may be accepted while reset is held.
      if (!rst_n_i) gnt_vld = 1'b0;
   end

   assign req_ready_o = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;
   assign mem_we_o    = gnt_vld & req_we_i[gnt_id];
   assign mem_addr_o  = gnt_vld ? req_addr_i[gnt_id*AW +: AW] : addr_q;
   assign mem_din_o   = req_wdata_i[gnt_id*WIDTH +: WIDTH];
   assign rd_push     = gnt_vld & ~req_we_i[gnt_id];

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      addr_d   = addr_q;
      if (gnt_vld) begin
         rr_ptr_d = (int'(gnt_id) == NUM_REQ-1) ? '0 : gnt_id + ID_W'(1);
         addr_d   = mem_addr_o;
      end
   end

   // Read-tracking pipe: depth matches RAM latency so the tag lines up with mem_dout.
   always_comb begin
      vld_pipe_d    = '0;
      id_pipe_d     = '0;
      vld_pipe_d[0] = rd_push;
      id_pipe_d[0]  = rd_push ? gnt_id : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
         id_pipe_d[i]  = id_pipe_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rr_ptr_q   <= '0;
         addr_q     <= '0;
         vld_pipe_q <= '0;
         id_pipe_q  <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         addr_q     <= addr_d;
         vld_pipe_q <= vld_pipe_d;
         id_pipe_q  <= id_pipe_d;
      end
   end

   assign rsp_valid_o = vld_pipe_q[RD_LATENCY-1];
   assign rsp_id_o    = id_pipe_q[RD_LATENCY-1];
   assign rsp_data_o  = mem_dout_i;

endmodule
